// File: rtl/spn_pkg.sv
// Shared types and constants for the 4-lane block transpose network.
package spn_pkg;

    localparam int unsigned LANES              = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned IDX_W              = 2;
    localparam int unsigned NUM_BANKS          = 2;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] lane_t;
    typedef lane_t [LANES-1:0]             beat_t;
    typedef logic [IDX_W-1:0]              idx_t;
    typedef logic                          bank_idx_t;

endpackage

// File: rtl/spn_bank.sv
// One 4x4 element block: whole rows are written, whole columns are read.
module spn_bank
    import spn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             wr_en,
    input  idx_t                             wr_row,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] wr_data,
    input  idx_t                             rd_col,
    output logic [LANES-1:0][DATA_WIDTH-1:0] rd_data_c
);

    // mem[row][lane]; contents are data only and need no reset
    logic [LANES-1:0][LANES-1:0][DATA_WIDTH-1:0] mem;

    // Row write: one input beat lands in one row
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    // Column read: lane l of the output beat is row l of the selected column
    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            rd_data_c[l] = mem[l][rd_col];
        end
    end

endmodule

// File: rtl/spn_transpose4.sv
// Streaming 4x4 block transpose with two ping-pong banks.
// Optional macro SPN_OUT_REG_EN adds one more output register stage.
module spn_transpose4
    import spn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_stream  [3:0],
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] output_stream [3:0],
    output logic                  valid_out
);

    logic                             valid_d1;
    idx_t                             wr_cnt;
    idx_t                             rd_cnt;
    bank_idx_t                        wr_ptr;
    bank_idx_t                        rd_ptr;
    logic [NUM_BANKS-1:0]             full;
    logic [NUM_BANKS-1:0]             full_nxt_c;
    logic                             read_c;
    logic                             wr_last_c;
    logic                             rd_last_c;
    logic                             wr_en0_c;
    logic                             wr_en1_c;
    logic [LANES-1:0][DATA_WIDTH-1:0] wr_beat_c;
    logic [LANES-1:0][DATA_WIDTH-1:0] rd_beat0_c;
    logic [LANES-1:0][DATA_WIDTH-1:0] rd_beat1_c;
    logic [LANES-1:0][DATA_WIDTH-1:0] rd_beat_c;
    logic [DATA_WIDTH-1:0]            out_q [3:0];
    logic                             valid_q;

    // Pack the input lanes into a beat and decode per-bank write enables
    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            wr_beat_c[l] = input_stream[l];
        end
        wr_en0_c  = valid_d1 && (wr_ptr == 1'b0);
        wr_en1_c  = valid_d1 && (wr_ptr == 1'b1);
        wr_last_c = valid_d1 && (wr_cnt == idx_t'(LANES - 1));
        read_c    = full[rd_ptr];
        rd_last_c = read_c && (rd_cnt == idx_t'(LANES - 1));
        rd_beat_c = (rd_ptr == 1'b1) ? rd_beat1_c : rd_beat0_c;
    end

    spn_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
        .clk       (clk),
        .wr_en     (wr_en0_c),
        .wr_row    (wr_cnt),
        .wr_data   (wr_beat_c),
        .rd_col    (rd_cnt),
        .rd_data_c (rd_beat0_c)
    );

    spn_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
        .clk       (clk),
        .wr_en     (wr_en1_c),
        .wr_row    (wr_cnt),
        .wr_data   (wr_beat_c),
        .rd_col    (rd_cnt),
        .rd_data_c (rd_beat1_c)
    );

    // Bank-full flags: freed after the last column, set on the last row
    always_comb begin
        full_nxt_c = full;
        if (rd_last_c) begin
            full_nxt_c[rd_ptr] = 1'b0;
        end
        if (wr_last_c) begin
            full_nxt_c[wr_ptr] = 1'b1;
        end
    end

    // Write side: valid pipeline, row counter and write bank pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d1 <= 1'b0;
            wr_cnt   <= '0;
            wr_ptr   <= 1'b0;
            full     <= '0;
        end else begin
            valid_d1 <= valid_in;
            full     <= full_nxt_c;
            if (valid_d1) begin
                wr_cnt <= wr_cnt + idx_t'(1);
            end
            if (wr_last_c) begin
                wr_ptr <= ~wr_ptr;
            end
        end
    end

    // Read side: stream four columns of a full bank into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= '0;
            rd_ptr  <= 1'b0;
            valid_q <= 1'b0;
            for (int l = 0; l < int'(LANES); l++) begin
                out_q[l] <= '0;
            end
        end else if (read_c) begin
            rd_cnt  <= rd_cnt + idx_t'(1);
            valid_q <= 1'b1;
            for (int l = 0; l < int'(LANES); l++) begin
                out_q[l] <= rd_beat_c[l];
            end
            if (rd_last_c) begin
                rd_ptr <= ~rd_ptr;
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

`ifdef SPN_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out2_q [3:0];
    logic                  valid2_q;

    // Extra retiming stage on the output beat and its valid
    always_ff @(posedge clk) begin
        if (rst) begin
            valid2_q <= 1'b0;
            for (int l = 0; l < int'(LANES); l++) begin
                out2_q[l] <= '0;
            end
        end else begin
            valid2_q <= valid_q;
            for (int l = 0; l < int'(LANES); l++) begin
                out2_q[l] <= out_q[l];
            end
        end
    end

    // Drive ports from the last register stage
    always_comb begin
        valid_out = valid2_q;
        for (int l = 0; l < int'(LANES); l++) begin
            output_stream[l] = out2_q[l];
        end
    end
`else
    // Drive ports from the output register
    always_comb begin
        valid_out = valid_q;
        for (int l = 0; l < int'(LANES); l++) begin
            output_stream[l] = out_q[l];
        end
    end
`endif

endmodule

// File: tb/tb_spn_transpose4.sv
// Bench for spn_transpose4: directed table, mid-block reset, random blocks.
module tb_spn_transpose4;
    import spn_pkg::*;

    localparam int unsigned DW = 16;
`ifdef SPN_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        beat_t rows [4];
        beat_t cols [4];
        int    gap_after;
        int    gap_len;
        int    idle_before;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          valid_out;
    logic [DW-1:0] input_stream  [3:0];
    logic [DW-1:0] output_stream [3:0];

    spn_transpose4 #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .input_stream  (input_stream),
        .valid_in      (valid_in),
        .output_stream (output_stream),
        .valid_out     (valid_out)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    logic  m_vd1 = 1'b0;
    int    wb    = 0;
    beat_t pend  = '0;
    beat_t last_out = '0;
    beat_t exp_q [$];
    beat_t exp_map [int];
    vec_t  tbl [5];

    function automatic beat_t mk(input int a, input int b, input int c, input int d);
        beat_t r;
        r[0] = lane_t'(a);
        r[1] = lane_t'(b);
        r[2] = lane_t'(c);
        r[3] = lane_t'(d);
        return r;
    endfunction

    function automatic void set_rows(input int idx, input int base);
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < 4; l++)
                tbl[idx].rows[r][l] = lane_t'(base + 4 * r + l);
    endfunction

    // One clock: drive inputs, advance the reference model, step an edge, check
    task automatic tick(input logic r, input logic v, input beat_t b);
        int    k;
        beat_t got;
        k = cyc + 1;
        rst      = r;
        valid_in = v;
        for (int l = 0; l < 4; l++) input_stream[l] = pend[l];
        if (r) begin
            m_vd1 = 1'b0;
            wb    = 0;
            exp_q.delete();
            exp_map.delete();
            last_out = '0;
        end else begin
            if (m_vd1) begin
                wb++;
                if (wb == 4) begin
                    wb = 0;
                    for (int j = 0; j < 4; j++) begin
                        if (exp_q.size() > 0) begin
                            exp_map[k + 1 + j + LAT] = exp_q.pop_front();
                        end else begin
                            n_vec++;
                            n_err++;
                            $display("FAIL no_expect edge %0d: block completed with no expected columns queued", k);
                        end
                    end
                end
            end
            m_vd1 = v;
        end
        pend = b;
        @(posedge clk);
        cyc = k;
        #1;
        for (int l = 0; l < 4; l++) got[l] = output_stream[l];
        n_vec++;
        if (exp_map.exists(k)) begin
            if (valid_out !== 1'b1 || got !== exp_map[k]) begin
                n_err++;
                $display("FAIL beat edge %0d: valid_out=%b data=%h, required valid_out=1 data=%h",
                         k, valid_out, got, exp_map[k]);
            end
            last_out = exp_map[k];
            exp_map.delete(k);
        end else begin
            if (valid_out !== 1'b0 || got !== last_out) begin
                n_err++;
                $display("FAIL idle edge %0d: valid_out=%b data=%h, required valid_out=0 data=%h",
                         k, valid_out, got, last_out);
            end
        end
    endtask

    task automatic send_block(input vec_t t);
        for (int i = 0; i < t.idle_before; i++) tick(1'b0, 1'b0, '0);
        for (int j = 0; j < 4; j++) exp_q.push_back(t.cols[j]);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, t.rows[i]);
            if (i == t.gap_after)
                for (int g = 0; g < t.gap_len; g++) tick(1'b0, 1'b0, '0);
        end
    endtask

    initial begin
        vec_t rv;

        // Directed table: single, gapped, back-to-back pair, post-reset block
        set_rows(0, 0);
        tbl[0].cols[0] = mk(0, 4, 8, 12);
        tbl[0].cols[1] = mk(1, 5, 9, 13);
        tbl[0].cols[2] = mk(2, 6, 10, 14);
        tbl[0].cols[3] = mk(3, 7, 11, 15);
        tbl[0].gap_after = -1; tbl[0].gap_len = 0; tbl[0].idle_before = 2;
        tbl[1] = tbl[0];
        tbl[1].gap_after = 1; tbl[1].gap_len = 2; tbl[1].idle_before = 4;
        tbl[2] = tbl[0];
        tbl[2].idle_before = 4;
        set_rows(3, 16);
        tbl[3].cols[0] = mk(16, 20, 24, 28);
        tbl[3].cols[1] = mk(17, 21, 25, 29);
        tbl[3].cols[2] = mk(18, 22, 26, 30);
        tbl[3].cols[3] = mk(19, 23, 27, 31);
        tbl[3].gap_after = -1; tbl[3].gap_len = 0; tbl[3].idle_before = 0;
        set_rows(4, 100);
        tbl[4].cols[0] = mk(100, 104, 108, 112);
        tbl[4].cols[1] = mk(101, 105, 109, 113);
        tbl[4].cols[2] = mk(102, 106, 110, 114);
        tbl[4].cols[3] = mk(103, 107, 111, 115);
        tbl[4].gap_after = -1; tbl[4].gap_len = 0; tbl[4].idle_before = 2;

        // Reset held, then idle: output must stay zero and invalid
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);

        // Table entries 0..3 (entries 2 and 3 are back to back)
        for (int i = 0; i < 4; i++) send_block(tbl[i]);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, '0);

        // Mid-block reset: two beats accepted, then reset, then a clean block
        tick(1'b0, 1'b1, mk(200, 201, 202, 203));
        tick(1'b0, 1'b1, mk(204, 205, 206, 207));
        tick(1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        send_block(tbl[4]);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, '0);

        // Random blocks against the transpose reference
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 4; r++)
                for (int l = 0; l < 4; l++)
                    rv.rows[r][l] = lane_t'($urandom);
            for (int j = 0; j < 4; j++)
                for (int l = 0; l < 4; l++)
                    rv.cols[j][l] = rv.rows[l][j];
            rv.gap_after   = int'($urandom_range(0, 4)) - 1;
            rv.gap_len     = int'($urandom_range(1, 3));
            rv.idle_before = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_block(rv);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);

        // Every expected beat must have been consumed
        n_vec++;
        if (exp_map.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d scheduled and %0d queued beats left, required 0 and 0",
                     exp_map.size(), exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spn_transpose4.md
Name: spn_transpose4

Overview:
- Streaming permutation network: 4 lanes, one 4x4 block transpose. Converts a row-ordered stream of 4-wide beats into a column-ordered stream.
- Sits between stages of the CNN datapath that need stride-4 reordering.
- Double-buffered, so back-to-back blocks are accepted with no stalls.

Parameters:
- DATA_WIDTH, 16, bit width of each lane element.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- input_stream  input  4 x DATA_WIDTH (unpacked array [3:0])  input beat, lane l = element l.
- valid_in  input  1  look-ahead valid: high in cycle c means input_stream carries a valid beat in cycle c+1.
- output_stream  output  4 x DATA_WIDTH (unpacked array [3:0])  permuted output beat.
- valid_out  output  1  output_stream valid this cycle.

Behaviour:
- Clocking and reset: one clock (clk); rst synchronous, active-high.
- While rst=1:
  - output_stream all 0, valid_out=0.
  - Internal valid pipeline, beat counters, bank pointers and bank-full flags cleared.
  - A partially written block is discarded. A block pending or in readout is dropped.
- Input acceptance:
  - valid_d1 registers valid_in each edge.
  - At an edge where valid_d1=1, input_stream is written into the current write bank as row r = write beat count (0..3).
  - Write beat count increments per accepted beat. Gaps (valid_d1=0) pause the count and do not corrupt the block.
- Block completion: on the 4th accepted beat the write bank is marked full, write pointer toggles, and write count wraps to 0.
- Permutation: the block is A[r][l], where r = beat (0..3) and l = lane (0..3). Output beat j, lane l = A[l][j], i.e. the transpose.
- Readout:
  - Starts at the edge after the completing write.
  - Four consecutive cycles, output_stream registered, valid_out=1, independent of further input gaps.
  - Bank is freed after beat 3; read pointer toggles.
  - Output holds its last value when valid_out=0.
- Latency: the first output beat appears one cycle after the last input beat of its block is sampled. With continuous input, output is continuous and delayed 4 cycles from the first input beat.
- Back-to-back blocks:
  - Readout of block k overlaps the writes of block k+1.
  - Block k+1 readout follows block k readout with no bubble.
  - Overflow is impossible: each block needs at least 4 cycles of writes, and at most 2 banks are in use.
- Simultaneous bank-full and readout end: the next readout starts the following edge.

Optional Feature:
- SPN_OUT_REG_EN defined: an extra output register stage on output_stream and valid_out. Latency grows by 1 cycle. Reset clears this stage too.
- Not defined: timing as specified above.

Decomposition:
- Package spn_pkg:
  - LANES=4 constant.
  - Default DATA_WIDTH.
  - typedef lane_t (logic [DATA_WIDTH-1:0]).
  - typedef beat_t (lane_t [LANES-1:0]).
  - Bank index type.
- Sub-module spn_bank: one 4x4 register block. Row-write port (row index, beat data, write enable). Column-read mux (column index -> beat). Instantiated twice in spn_transpose4.

Test Plan:
- Reset idle: rst held 10 cycles, then valid_in=0 -> valid_out=0 and output_stream=0 throughout.
- Single block: beats {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15} (valid_in one cycle ahead) -> four valid beats {0,4,8,12},{1,5,9,13},{2,6,10,14},{3,7,11,15}, the first one cycle after beat 3 is sampled.
- Back-to-back: two blocks (0..15, then 16..31) continuous -> 8 consecutive valid beats, second block {16,20,24,28}..., no bubble.
- Gapped input: block 0..15 with 2 idle cycles between beats 1 and 2 -> same transposed output; readout starts one cycle after the last beat; valid_out stays high 4 consecutive cycles.
- Mid-block reset: 2 beats accepted, rst pulsed, then full block 100..115 -> only {100,104,108,112}... emitted; the earlier beats never appear.
- Macro variant: SPN_OUT_REG_EN defined, single-block test -> identical data, every valid_out assertion one cycle later.
